rect_draw_engine: RTL and testbench

- Parametrised successor rectangle rasteriser for the VGA drawing path.
- Accepts a rectangle (origin, size, colour, mode) with a start/busy/done handshake, then emits one pixel write per clock to the VGA adapter.
- Emits pixels in column-major order, ascending.
- Adds outline mode, screen clipping, zero-size handling and abort.
- Used by brick, paddle and ball drawing, and by screen clear.

---
 rtl/rect_draw_engine.sv | 155 +++++++++++++++
 tb/tb_rect_draw_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: walks a latched rectangle column-major and emits one
// pixel write per cycle, with outline mode, screen clipping and abort.
module rect_draw_engine #(
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned COLOR_W  = 3,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               mode,
    output logic               busy,
    output logic               done,
    output logic               writeEn,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic [COLOR_W-1:0] color_out
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDraw   = 2'd1,
        StFinish = 2'd2
    } state_e;

    // Screen limits widened by one bit so they compare against carry-extended sums.
    localparam logic [COORD_W:0] ScrW = (COORD_W + 1)'(SCREEN_W);
    localparam logic [COORD_W:0] ScrH = (COORD_W + 1)'(SCREEN_H);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] x_base_q, x_base_d;
    logic [COORD_W-1:0] y_base_q, y_base_d;
    logic [COORD_W-1:0] w_q, w_d;
    logic [COORD_W-1:0] h_q, h_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               mode_q, mode_d;
    logic [COORD_W-1:0] cx_q, cx_d;
    logic [COORD_W-1:0] cy_q, cy_d;

    logic               cx_last;
    logic               cy_last;
    logic               drawing;
    logic [COORD_W:0]   x_sum;
    logic [COORD_W:0]   y_sum;
    logic               in_clip;
    logic               on_border;

    // State and latched-parameter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            x_base_q <= '0;
            y_base_q <= '0;
            w_q      <= '0;
            h_q      <= '0;
            color_q  <= '0;
            mode_q   <= 1'b0;
            cx_q     <= '0;
            cy_q     <= '0;
        end else begin
            state_q  <= state_d;
            x_base_q <= x_base_d;
            y_base_q <= y_base_d;
            w_q      <= w_d;
            h_q      <= h_d;
            color_q  <= color_d;
            mode_q   <= mode_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
        end
    end

    // Counter end-of-row/column flags; only meaningful in DRAW where w_q, h_q >= 1.
    always_comb begin
        cx_last = (cx_q == w_q - 1'b1);
        cy_last = (cy_q == h_q - 1'b1);
    end

    // Next-state: request latch in IDLE, column-major walk in DRAW.
    always_comb begin
        state_d  = state_q;
        x_base_d = x_base_q;
        y_base_d = y_base_q;
        w_d      = w_q;
        h_d      = h_q;
        color_d  = color_q;
        mode_d   = mode_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    x_base_d = x_in;
                    y_base_d = y_in;
                    w_d      = width;
                    h_d      = height;
                    color_d  = color_in;
                    mode_d   = mode;
                    cx_d     = '0;
                    cy_d     = '0;
                    if (width == '0 || height == '0) begin
                        state_d = StFinish;
                    end else begin
                        state_d = StDraw;
                    end
                end
            end
            StDraw: begin
                if (abort) begin
                    state_d = StIdle;
                    cx_d    = '0;
                    cy_d    = '0;
                end else if (cx_last && cy_last) begin
                    state_d = StFinish;
                    cx_d    = '0;
                    cy_d    = '0;
                end else if (cy_last) begin
                    cy_d = '0;
                    cx_d = cx_q + 1'b1;
                end else begin
                    cy_d = cy_q + 1'b1;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pixel outputs: clip on the carry-extended sums so nothing wraps onto the screen.
    always_comb begin
        drawing   = (state_q == StDraw);
        x_sum     = {1'b0, x_base_q} + {1'b0, cx_q};
        y_sum     = {1'b0, y_base_q} + {1'b0, cy_q};
        in_clip   = !x_sum[COORD_W] && (x_sum < ScrW) && !y_sum[COORD_W] && (y_sum < ScrH);
        on_border = (cx_q == '0) || cx_last || (cy_q == '0) || cy_last;
        busy      = drawing;
        done      = (state_q == StFinish);
        writeEn   = drawing && in_clip && (!mode_q || on_border);
        x_out     = drawing ? x_sum[COORD_W-1:0] : '0;
        y_out     = drawing ? y_sum[COORD_W-1:0] : '0;
        color_out = drawing ? color_q : '0;
    end

endmodule

// File: tb/tb_rect_draw_engine.sv
// Scoreboard bench for rect_draw_engine: expected pixels are queued by the
// stimulus thread and popped by a monitor on every observed write strobe.
module tb_rect_draw_engine;

    localparam int CW = 10;
    localparam int KW = 3;
    localparam int PW = 2 * CW + KW;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] x_in = '0;
    logic [CW-1:0] y_in = '0;
    logic [CW-1:0] width = '0;
    logic [CW-1:0] height = '0;
    logic [KW-1:0] color_in = '0;
    logic          mode = 1'b0;
    logic          busy;
    logic          done;
    logic          writeEn;
    logic [CW-1:0] x_out;
    logic [CW-1:0] y_out;
    logic [KW-1:0] color_out;

    int checks = 0;
    int failures = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] mon_e;

    rect_draw_engine #(
        .COORD_W (CW),
        .COLOR_W (KW),
        .SCREEN_W(160),
        .SCREEN_H(120)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .abort    (abort),
        .x_in     (x_in),
        .y_in     (y_in),
        .width    (width),
        .height   (height),
        .color_in (color_in),
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .writeEn  (writeEn),
        .x_out    (x_out),
        .y_out    (y_out),
        .color_out(color_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_px(input int x, input int y, input int c);
        exp_q.push_back({CW'(x), CW'(y), KW'(c)});
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (resetn === 1'b1 && writeEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got x=%0d y=%0d c=%0d expected no write",
                         x_out, y_out, color_out);
            end else begin
                mon_e = exp_q.pop_front();
                if ({x_out, y_out, color_out} !== mon_e) begin
                    checks++;
                    failures++;
                    $display("FAIL pixel: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                             x_out, y_out, color_out, mon_e[PW-1 -: CW], mon_e[KW +: CW],
                             mon_e[KW-1:0]);
                end else begin
                    checks++;
                end
            end
        end
    end

    task automatic scramble_inputs();
        x_in     = CW'($urandom);
        y_in     = CW'($urandom);
        width    = CW'($urandom);
        height   = CW'($urandom);
        color_in = KW'($urandom);
        mode     = 1'($urandom);
    endtask

    // Issue one request, poke start while busy and in FINISH, and check
    // DRAW cycle count, done timing and the idle cycle that follows.
    task automatic run_rect(input string name, input int x, input int y, input int w,
                            input int h, input int c, input logic m, input logic ab,
                            input int exp_cycles);
        int bc = 0;
        int done_at = -1;
        @(posedge clk);
        #1;
        x_in = CW'(x); y_in = CW'(y); width = CW'(w); height = CW'(h);
        color_in = KW'(c); mode = m; start = 1'b1; abort = ab;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        scramble_inputs();
        for (int i = 0; i < exp_cycles + 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1) bc++;
            if (done === 1'b1) begin
                done_at = i;
                break;
            end
            start = (i == 1);
        end
        chk({name, "_draw_cycles"}, bc, exp_cycles);
        chk({name, "_done_cycle"}, done_at, exp_cycles);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_idle_busy"}, {31'b0, busy}, 0);
        chk({name, "_idle_done"}, {31'b0, done}, 0);
        chk({name, "_all_writes_seen"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dseen;
        #12;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_we", {31'b0, writeEn}, 0);
        chk("rst_coords", {12'b0, x_out, y_out}, 0);
        chk("rst_color", {29'b0, color_out}, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Filled, in bounds.
        push_px(10, 20, 5); push_px(10, 21, 5); push_px(11, 20, 5);
        push_px(11, 21, 5); push_px(12, 20, 5); push_px(12, 21, 5);
        run_rect("fill", 10, 20, 3, 2, 5, 1'b0, 1'b0, 6);

        // Outline 4x4: interior (1..2, 1..2) suppressed.
        push_px(0, 0, 1); push_px(0, 1, 1); push_px(0, 2, 1); push_px(0, 3, 1);
        push_px(1, 0, 1); push_px(1, 3, 1); push_px(2, 0, 1); push_px(2, 3, 1);
        push_px(3, 0, 1); push_px(3, 1, 1); push_px(3, 2, 1); push_px(3, 3, 1);
        run_rect("outline", 0, 0, 4, 4, 1, 1'b1, 1'b0, 16);

        // Clipped at the bottom-right corner.
        push_px(158, 118, 4); push_px(158, 119, 4);
        push_px(159, 118, 4); push_px(159, 119, 4);
        run_rect("clip", 158, 118, 4, 4, 4, 1'b0, 1'b0, 16);

        // Column sum carries out of COORD_W: must not wrap onto the screen.
        run_rect("carry", 1020, 0, 8, 1, 7, 1'b0, 1'b0, 8);

        // Zero width: straight to FINISH.
        run_rect("zero", 7, 7, 0, 5, 3, 1'b0, 1'b0, 0);

        // One-wide outline writes every pixel.
        push_px(30, 40, 2); push_px(30, 41, 2); push_px(30, 42, 2);
        run_rect("outline_1w", 30, 40, 1, 3, 2, 1'b1, 1'b0, 3);

        // Abort on the third DRAW cycle of a 4x4 fill.
        push_px(20, 30, 6); push_px(20, 31, 6); push_px(20, 32, 6);
        @(posedge clk);
        #1;
        x_in = 20; y_in = 30; width = 4; height = 4; color_in = 6; mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_inputs();
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 1);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_busy", {31'b0, busy}, 0);
        dseen = (done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dseen++;
        end
        chk("abort_no_done", dseen, 0);
        chk("abort_writes", exp_q.size(), 0);

        // Restart with abort held alongside start: start wins in IDLE.
        push_px(100, 50, 2); push_px(100, 51, 2); push_px(101, 50, 2); push_px(101, 51, 2);
        run_rect("restart", 100, 50, 2, 2, 2, 1'b0, 1'b1, 4);

        // Asynchronous reset in the middle of a draw.
        push_px(5, 5, 7); push_px(5, 6, 7);
        @(posedge clk);
        #1;
        x_in = 5; y_in = 5; width = 4; height = 4; color_in = 7; mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_pre_busy", {31'b0, busy}, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rstmid_we", {31'b0, writeEn}, 0);
        chk("rstmid_busy", {31'b0, busy}, 0);
        chk("rstmid_done", {31'b0, done}, 0);
        chk("rstmid_coords", {12'b0, x_out, y_out}, 0);
        chk("rstmid_color", {29'b0, color_out}, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rstmid_idle", {31'b0, busy}, 0);
        chk("rstmid_writes", exp_q.size(), 0);

        // Normal operation after reset, on the last visible row.
        push_px(0, 119, 5); push_px(1, 119, 5);
        run_rect("post_reset", 0, 119, 2, 1, 5, 1'b0, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
